// File: rtl/reu_pkg.sv
// REU register file shared definitions: register offsets, transfer type
// codes, register bit positions and reset constants.
package reu_pkg;

  localparam logic [4:0] REG_STATUS   = 5'h00;
  localparam logic [4:0] REG_CMD      = 5'h01;
  localparam logic [4:0] REG_CA_LO    = 5'h02;
  localparam logic [4:0] REG_CA_HI    = 5'h03;
  localparam logic [4:0] REG_REUA_LO  = 5'h04;
  localparam logic [4:0] REG_REUA_MID = 5'h05;
  localparam logic [4:0] REG_REUA_BNK = 5'h06;
  localparam logic [4:0] REG_LEN_LO   = 5'h07;
  localparam logic [4:0] REG_LEN_HI   = 5'h08;
  localparam logic [4:0] REG_IMR      = 5'h09;
  localparam logic [4:0] REG_ACR      = 5'h0A;

  typedef enum logic [1:0] {
    XFER_C64REU = 2'd0,
    XFER_REUC64 = 2'd1,
    XFER_SWAP   = 2'd2,
    XFER_VERIFY = 2'd3
  } xfer_e;

  localparam int unsigned ST_IRQ       = 7;
  localparam int unsigned ST_EOB       = 6;
  localparam int unsigned ST_VERR      = 5;
  localparam int unsigned ST_SIZE      = 4;

  localparam int unsigned CMD_EXEC     = 7;
  localparam int unsigned CMD_AUTOLOAD = 5;
  localparam int unsigned CMD_FF00DIS  = 4;

  localparam int unsigned IMR_IE       = 7;
  localparam int unsigned IMR_EOBM     = 6;
  localparam int unsigned IMR_VERRM    = 5;

  localparam int unsigned ACR_FIXCA    = 7;
  localparam int unsigned ACR_FIXREUA  = 6;

  localparam logic [15:0] LEN_RESET    = 16'hFFFF;

endpackage

// File: rtl/reu_shadow_counter.sv
// Working register plus autoload shadow copy.
//   clk      : state clock (falling edge active)
//   rst      : synchronous active-high reset to RESET_VAL (both copies)
//   wrEn     : per-byte-lane CPU write enables; writes working and shadow
//   wrData   : CPU write byte, applied to every enabled lane
//   step     : increment (DOWN=0) or decrement (DOWN=1) request
//   fix      : suppresses step
//   autoload : reload working value from shadow
//   value    : working value
// Priority: CPU write > autoload > step.
module reu_shadow_counter #(
  parameter int unsigned W         = 16,
  parameter int unsigned NB        = (W + 7) / 8,
  parameter logic [W-1:0] RESET_VAL = '0,
  parameter bit          DOWN      = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NB-1:0] wrEn,
  input  logic [7:0]    wrData,
  input  logic          step,
  input  logic          fix,
  input  logic          autoload,
  output logic [W-1:0]  value
);

  logic [W-1:0] shadow;
  logic [W-1:0] loadVal;
  logic [W-1:0] shadowNext;
  logic [W-1:0] valueNext;

  always_comb begin
    loadVal    = value;
    shadowNext = shadow;
    for (int unsigned i = 0; i < W; i++) begin
      if (wrEn[i / 8]) begin
        loadVal[i]    = wrData[i % 8];
        shadowNext[i] = wrData[i % 8];
      end
    end
    valueNext = value;
    if (|wrEn) begin
      // unwritten lanes hold; a write suppresses any step/reload this edge
      valueNext = loadVal;
    end else if (autoload) begin
      valueNext = shadow;
    end else if (step && !fix) begin
      valueNext = DOWN ? value - 1'b1 : value + 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      value  <= RESET_VAL;
      shadow <= RESET_VAL;
    end else begin
      value  <= valueNext;
      shadow <= shadowNext;
    end
  end

endmodule

// File: rtl/reu_regfile.sv
// CPU-visible REU register file ($DF00-$DF0A, mirrored every 32 bytes).
//   PHI2      : system clock, all state on the falling edge
//   RegReset  : synchronous active-high reset
//   IOSel/RW/A/Din/Dout : CPU register window access (Dout combinational)
//   FF00Wr    : qualified CPU write to $FF00 (deferred start trigger)
//   NextCA/NextREUA/XferEnd/VerifyErr/Autoload : events from dma_seq
//   Execute/XferType/Length1/CA/REUA : controls and addresses to dma_seq
//   nIRQ      : registered active-low interrupt
// REUA_W is expected in 17..24 so the REU address spans exactly three bytes.
module reu_regfile
  import reu_pkg::*;
#(
  parameter int unsigned REUA_W   = 19,
  parameter bit          SIZE_BIT = 1'b1
) (
  input  logic              PHI2,
  input  logic              RegReset,
  input  logic              IOSel,
  input  logic              RW,
  input  logic [4:0]        A,
  input  logic [7:0]        Din,
  output logic [7:0]        Dout,
  input  logic              FF00Wr,
  input  logic              NextCA,
  input  logic              NextREUA,
  input  logic              XferEnd,
  input  logic              VerifyErr,
  input  logic              Autoload,
  output logic              Execute,
  output logic [1:0]        XferType,
  output logic              Length1,
  output logic [15:0]       CA,
  output logic [REUA_W-1:0] REUA,
  output logic              nIRQ
);

  localparam int unsigned REUA_NB = (REUA_W + 7) / 8;

  logic        exec, autoloadEn, ff00Dis, ff00Seen;
  logic        ie, eobm, verrm, fixCa, fixReua;
  logic        eob, verr;
  logic        wr, rdStatus, wrCmd, execNext, armed, irqFlag, doAutoload;
  logic [1:0]  caWr, lenWr;
  logic [REUA_NB-1:0] reuaWr;
  logic [15:0] len;
  logic [7:0]  bankByte;

  assign wr         = IOSel && !RW;
  assign rdStatus   = IOSel && RW && (A == REG_STATUS);
  assign wrCmd      = wr && (A == REG_CMD);
  assign doAutoload = Autoload && autoloadEn;

  always_comb begin
    caWr      = '0;
    lenWr     = '0;
    reuaWr    = '0;
    caWr[0]   = wr && (A == REG_CA_LO);
    caWr[1]   = wr && (A == REG_CA_HI);
    reuaWr[0] = wr && (A == REG_REUA_LO);
    reuaWr[1] = wr && (A == REG_REUA_MID);
    reuaWr[2] = wr && (A == REG_REUA_BNK);
    lenWr[0]  = wr && (A == REG_LEN_LO);
    lenWr[1]  = wr && (A == REG_LEN_HI);
  end

  reu_shadow_counter #(.W(16), .RESET_VAL(16'h0000), .DOWN(1'b0)) caCnt (
    .clk(PHI2), .rst(RegReset), .wrEn(caWr), .wrData(Din),
    .step(NextCA), .fix(fixCa), .autoload(doAutoload), .value(CA)
  );

  reu_shadow_counter #(.W(REUA_W), .RESET_VAL('0), .DOWN(1'b0)) reuaCnt (
    .clk(PHI2), .rst(RegReset), .wrEn(reuaWr), .wrData(Din),
    .step(NextREUA), .fix(fixReua), .autoload(doAutoload), .value(REUA)
  );

  reu_shadow_counter #(.W(16), .RESET_VAL(LEN_RESET), .DOWN(1'b1)) lenCnt (
    .clk(PHI2), .rst(RegReset), .wrEn(lenWr), .wrData(Din),
    .step(NextCA), .fix(1'b0), .autoload(doAutoload), .value(len)
  );

  // CPU write of EXEC beats a concurrent XferEnd
  assign execNext = wrCmd ? Din[CMD_EXEC] : (XferEnd ? 1'b0 : exec);
  assign armed    = exec && (ff00Dis || ff00Seen);
  assign irqFlag  = ie && ((eob && eobm) || (verr && verrm));
  assign Length1  = (len == 16'h0001);

  always_ff @(negedge PHI2) begin
    if (RegReset) begin
      exec       <= 1'b0;
      autoloadEn <= 1'b0;
      ff00Dis    <= 1'b0;
      XferType   <= '0;
      ff00Seen   <= 1'b0;
      ie         <= 1'b0;
      eobm       <= 1'b0;
      verrm      <= 1'b0;
      fixCa      <= 1'b0;
      fixReua    <= 1'b0;
      eob        <= 1'b0;
      verr       <= 1'b0;
      Execute    <= 1'b0;
      nIRQ       <= 1'b1;
    end else begin
      exec <= execNext;
      if (wrCmd) begin
        autoloadEn <= Din[CMD_AUTOLOAD];
        ff00Dis    <= Din[CMD_FF00DIS];
        XferType   <= Din[1:0];
      end
      if (wr && (A == REG_IMR)) begin
        ie    <= Din[IMR_IE];
        eobm  <= Din[IMR_EOBM];
        verrm <= Din[IMR_VERRM];
      end
      if (wr && (A == REG_ACR)) begin
        fixCa   <= Din[ACR_FIXCA];
        fixReua <= Din[ACR_FIXREUA];
      end
      // a new start always needs a fresh $FF00 write
      if (!execNext || XferEnd) begin
        ff00Seen <= 1'b0;
      end else if (FF00Wr && exec && !ff00Dis) begin
        ff00Seen <= 1'b1;
      end
      // set wins over clear-on-read
      if (XferEnd) begin
        eob <= 1'b1;
      end else if (rdStatus) begin
        eob <= 1'b0;
      end
      if (VerifyErr) begin
        verr <= 1'b1;
      end else if (rdStatus) begin
        verr <= 1'b0;
      end
      Execute <= armed;
      nIRQ    <= !irqFlag;
    end
  end

  always_comb begin
    bankByte                = '1;
    bankByte[REUA_W-17:0]   = REUA[REUA_W-1:16];
  end

  always_comb begin
    Dout = 8'hFF;
    case (A)
      REG_STATUS: begin
        Dout          = '0;
        Dout[ST_IRQ]  = irqFlag;
        Dout[ST_EOB]  = eob;
        Dout[ST_VERR] = verr;
        Dout[ST_SIZE] = SIZE_BIT;
      end
      REG_CMD: begin
        Dout[CMD_EXEC]     = exec;
        Dout[CMD_AUTOLOAD] = autoloadEn;
        Dout[CMD_FF00DIS]  = ff00Dis;
        Dout[1:0]          = XferType;
      end
      REG_CA_LO:    Dout = CA[7:0];
      REG_CA_HI:    Dout = CA[15:8];
      REG_REUA_LO:  Dout = REUA[7:0];
      REG_REUA_MID: Dout = REUA[15:8];
      REG_REUA_BNK: Dout = bankByte;
      REG_LEN_LO:   Dout = len[7:0];
      REG_LEN_HI:   Dout = len[15:8];
      REG_IMR: begin
        Dout[IMR_IE]    = ie;
        Dout[IMR_EOBM]  = eobm;
        Dout[IMR_VERRM] = verrm;
      end
      REG_ACR: begin
        Dout[ACR_FIXCA]   = fixCa;
        Dout[ACR_FIXREUA] = fixReua;
      end
      default: Dout = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_reu_regfile.sv
module tb_reu_regfile;

  logic        PHI2 = 1'b1;
  logic        RegReset = 1'b1;
  logic        IOSel = 1'b0;
  logic        RW = 1'b1;
  logic [4:0]  A = '0;
  logic [7:0]  Din = '0;
  logic [7:0]  Dout;
  logic        FF00Wr = 1'b0;
  logic        NextCA = 1'b0;
  logic        NextREUA = 1'b0;
  logic        XferEnd = 1'b0;
  logic        VerifyErr = 1'b0;
  logic        Autoload = 1'b0;
  logic        Execute;
  logic [1:0]  XferType;
  logic        Length1;
  logic [15:0] CA;
  logic [18:0] REUA;
  logic        nIRQ;

  int tests = 0;
  int failed = 0;

  reu_regfile #(.REUA_W(19), .SIZE_BIT(1'b1)) dut (
    .PHI2(PHI2), .RegReset(RegReset), .IOSel(IOSel), .RW(RW), .A(A),
    .Din(Din), .Dout(Dout), .FF00Wr(FF00Wr), .NextCA(NextCA),
    .NextREUA(NextREUA), .XferEnd(XferEnd), .VerifyErr(VerifyErr),
    .Autoload(Autoload), .Execute(Execute), .XferType(XferType),
    .Length1(Length1), .CA(CA), .REUA(REUA), .nIRQ(nIRQ)
  );

  always #5 PHI2 = ~PHI2;

  // advance past one falling edge, sample 1 time unit later
  task automatic step();
    @(negedge PHI2);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic wrReg(input logic [4:0] addr, input logic [7:0] data);
    IOSel = 1'b1; RW = 1'b0; A = addr; Din = data;
    step();
    IOSel = 1'b0; RW = 1'b1;
  endtask

  // combinational read, no edge so no side effects
  task automatic rdReg(input logic [4:0] addr, input logic [7:0] exp, input string name);
    IOSel = 1'b1; RW = 1'b1; A = addr;
    #1;
    chk(name, {24'h0, Dout}, {24'h0, exp});
    IOSel = 1'b0;
  endtask

  // status read across an edge clears EOB/VERR
  task automatic clearStatus();
    IOSel = 1'b1; RW = 1'b1; A = 5'h00;
    step();
    IOSel = 1'b0;
  endtask

  initial begin
    // reset state
    step(); step();
    RegReset = 1'b0;
    rdReg(5'h00, 8'h10, "rst_status");
    rdReg(5'h01, 8'h4C, "rst_cmd");
    rdReg(5'h02, 8'h00, "rst_ca_lo");
    rdReg(5'h03, 8'h00, "rst_ca_hi");
    rdReg(5'h04, 8'h00, "rst_reua_lo");
    rdReg(5'h05, 8'h00, "rst_reua_mid");
    rdReg(5'h06, 8'hF8, "rst_reua_bank");
    rdReg(5'h07, 8'hFF, "rst_len_lo");
    rdReg(5'h08, 8'hFF, "rst_len_hi");
    rdReg(5'h09, 8'h1F, "rst_imr");
    rdReg(5'h0A, 8'h3F, "rst_acr");
    rdReg(5'h0B, 8'hFF, "rst_unused_b");
    rdReg(5'h1F, 8'hFF, "rst_unused_1f");
    chk("rst_execute", {31'h0, Execute}, 32'h0);
    chk("rst_nirq", {31'h0, nIRQ}, 32'h1);
    chk("rst_length1", {31'h0, Length1}, 32'h0);

    // immediate execute with FF00DIS, one step
    wrReg(5'h02, 8'h00); wrReg(5'h03, 8'hC0);
    wrReg(5'h04, 8'h45); wrReg(5'h05, 8'h23); wrReg(5'h06, 8'h01);
    wrReg(5'h07, 8'h02); wrReg(5'h08, 8'h00);
    wrReg(5'h00, 8'hFF);
    rdReg(5'h00, 8'h10, "status_write_ignored");
    chk("len2_length1", {31'h0, Length1}, 32'h0);
    wrReg(5'h01, 8'h90);
    chk("exec_latency0", {31'h0, Execute}, 32'h0);
    NextCA = 1'b1; NextREUA = 1'b1;
    step();
    NextCA = 1'b0; NextREUA = 1'b0;
    chk("exec_latency1", {31'h0, Execute}, 32'h1);
    chk("ca_step", {16'h0, CA}, 32'h0000C001);
    chk("reua_step", {13'h0, REUA}, 32'h00012346);
    chk("length1_set", {31'h0, Length1}, 32'h1);
    rdReg(5'h08, 8'h00, "len_hi_step");
    rdReg(5'h07, 8'h01, "len_lo_step");
    rdReg(5'h01, 8'hDC, "cmd_readback");
    XferEnd = 1'b1; step(); XferEnd = 1'b0;
    step();
    chk("xferend_exec_drop", {31'h0, Execute}, 32'h0);
    rdReg(5'h00, 8'h50, "status_eob");
    clearStatus();
    rdReg(5'h00, 8'h10, "status_eob_cleared");

    // deferred start via $FF00
    FF00Wr = 1'b1; step(); FF00Wr = 1'b0;
    wrReg(5'h01, 8'h80);
    step(); step();
    chk("ff00_idle_ignored", {31'h0, Execute}, 32'h0);
    FF00Wr = 1'b1; step(); FF00Wr = 1'b0;
    chk("ff00_latency0", {31'h0, Execute}, 32'h0);
    step();
    chk("ff00_execute", {31'h0, Execute}, 32'h1);
    XferEnd = 1'b1; step(); XferEnd = 1'b0;
    step();
    chk("ff00_xferend_drop", {31'h0, Execute}, 32'h0);
    rdReg(5'h00, 8'h50, "ff00_status_eob");
    clearStatus();

    // autoload: shadows CA=C000 REUA=012345 LEN=0002
    wrReg(5'h01, 8'hB0);
    NextCA = 1'b1; NextREUA = 1'b1;
    repeat (5) step();
    NextCA = 1'b0; NextREUA = 1'b0;
    chk("al_ca_stepped", {16'h0, CA}, 32'h0000C006);
    chk("al_reua_stepped", {13'h0, REUA}, 32'h0001234B);
    rdReg(5'h08, 8'hFF, "len_wrap_hi");
    rdReg(5'h07, 8'hFC, "len_wrap_lo");
    Autoload = 1'b1; XferEnd = 1'b1; NextCA = 1'b1; NextREUA = 1'b1;
    step();
    Autoload = 1'b0; XferEnd = 1'b0; NextCA = 1'b0; NextREUA = 1'b0;
    chk("al_ca", {16'h0, CA}, 32'h0000C000);
    chk("al_reua", {13'h0, REUA}, 32'h00012345);
    rdReg(5'h07, 8'h02, "al_len_lo");
    rdReg(5'h01, 8'h7C, "al_exec_clear");
    clearStatus();
    wrReg(5'h01, 8'h00);
    Autoload = 1'b1; NextCA = 1'b1; step(); Autoload = 1'b0; NextCA = 1'b0;
    chk("al_disabled_steps", {16'h0, CA}, 32'h0000C001);

    // interrupts (LEN now 0001)
    wrReg(5'h09, 8'hE0);
    rdReg(5'h09, 8'hFF, "imr_readback");
    VerifyErr = 1'b1; step(); VerifyErr = 1'b0;
    rdReg(5'h00, 8'hB0, "status_verr_irq");
    chk("nirq_latency0", {31'h0, nIRQ}, 32'h1);
    step();
    chk("nirq_asserted", {31'h0, nIRQ}, 32'h0);
    clearStatus();
    rdReg(5'h00, 8'h10, "verr_cleared");
    chk("nirq_still_low", {31'h0, nIRQ}, 32'h0);
    step();
    chk("nirq_released", {31'h0, nIRQ}, 32'h1);
    IOSel = 1'b1; RW = 1'b1; A = 5'h00; VerifyErr = 1'b1;
    step();
    IOSel = 1'b0; VerifyErr = 1'b0;
    rdReg(5'h00, 8'hB0, "read_vs_verr_set_wins");
    clearStatus();
    XferEnd = 1'b1; wrReg(5'h01, 8'h90); XferEnd = 1'b0;
    rdReg(5'h01, 8'hDC, "write_exec_vs_xferend");
    wrReg(5'h01, 8'h00);
    clearStatus();
    step();

    // fixed REU address, then wrap
    wrReg(5'h0A, 8'h40);
    rdReg(5'h0A, 8'h7F, "acr_readback");
    wrReg(5'h04, 8'hFF); wrReg(5'h05, 8'hFF); wrReg(5'h06, 8'h07);
    NextREUA = 1'b1; repeat (3) step(); NextREUA = 1'b0;
    chk("reua_fixed", {13'h0, REUA}, 32'h0007FFFF);
    wrReg(5'h0A, 8'h00);
    NextREUA = 1'b1; step(); NextREUA = 1'b0;
    chk("reua_wrap", {13'h0, REUA}, 32'h00000000);

    // CA wrap; LEN 0001 -> 0000
    wrReg(5'h02, 8'hFF); wrReg(5'h03, 8'hFF);
    NextCA = 1'b1; step(); NextCA = 1'b0;
    chk("ca_wrap", {16'h0, CA}, 32'h00000000);
    chk("len0_length1", {31'h0, Length1}, 32'h0);
    // CPU write beats NextCA on CA; LEN still decrements to FFFF
    NextCA = 1'b1; wrReg(5'h02, 8'h55); NextCA = 1'b0;
    chk("write_vs_nextca", {16'h0, CA}, 32'h00000055);
    rdReg(5'h07, 8'hFF, "len_dec_on_write");

    // reset mid-transfer
    wrReg(5'h01, 8'h90);
    step();
    chk("pre_reset_execute", {31'h0, Execute}, 32'h1);
    RegReset = 1'b1; step(); RegReset = 1'b0;
    chk("midreset_execute", {31'h0, Execute}, 32'h0);
    chk("midreset_ca", {16'h0, CA}, 32'h0);
    rdReg(5'h01, 8'h4C, "midreset_cmd");
    rdReg(5'h08, 8'hFF, "midreset_len_hi");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/reu_regfile.md
Name: reu_regfile

Overview:
- CPU-visible REU register file at $DF00-$DF0A, mirrored every 32 bytes in IO2.
- Holds command, C64 address, REU address, length and interrupt registers, each address/length register with an autoload shadow copy.
- Drives Execute, XferType and Length1 into dma_seq.
- Consumes NextCA, NextREUA, XferEnd, VerifyErr and Autoload from dma_seq to step counters, set status flags and raise nIRQ.

Parameters:
- REUA_W, 19, REU address width; 19 = 512 KB, bank register bits [REUA_W-17:0] are used.
- SIZE_BIT, 1, value returned in status bit 4 (1 = 256Kx1 DRAM type).

Ports:
- PHI2 input 1: system clock; all state updates on the falling edge.
- RegReset input 1: synchronous active-high reset, sampled on the falling edge of PHI2.
- IOSel input 1: IO2 select for the REU register window.
- RW input 1: CPU R/W; 1 = read.
- A input 5: CPU address bits 4:0.
- Din input 8: CPU write data.
- Dout output 8: register read data (combinational).
- FF00Wr input 1: decoded CPU write to $FF00, one-cycle qualified.
- NextCA input 1: step C64 address and length.
- NextREUA input 1: step REU address.
- XferEnd input 1: transfer finished.
- VerifyErr input 1: verify mismatch.
- Autoload input 1: reload working registers from shadows.
- Execute output 1: start request to dma_seq.
- XferType output 2: command bits 1:0.
- Length1 output 1: working length == 1.
- CA output 16: working C64 address.
- REUA output REUA_W: working REU address.
- nIRQ output 1: open-drain-style active-low IRQ; 0 = asserted.

Behaviour:
- Register write: on the falling edge with IOSel && !RW, A=0..A writes working and shadow copies. Writes to A=0 (status) and A=B..1F are ignored.
- Register map:
  - 0 status (R): b7 IRQ, b6 EOB, b5 VERR, b4 SIZE_BIT, b3:0 = 0.
  - 1 command: b7 EXEC, b5 AUTOLOAD, b4 FF00DIS, b1:0 TYPE; other bits read 1.
  - 2/3 CA lo/hi.
  - 4/5/6 REUA lo/mid/bank; unused bank bits read 1.
  - 7/8 LEN lo/hi.
  - 9 IMR: b7 IE, b6 EOBM, b5 VERRM; low bits read 1.
  - A ACR: b7 FIXCA, b6 FIXREUA; low bits read 1.
  - B..1F read $FF.
- Status read: on the falling edge with IOSel && RW && A=0, EOB and VERR are cleared.
- Execute:
  - Armed = EXEC && (FF00DIS || ff00_seen).
  - ff00_seen is set by FF00Wr while EXEC=1 && FF00DIS=0, and cleared when EXEC clears.
  - Execute = registered Armed, one-cycle latency after the enabling edge.
- NextCA: CA += 1 unless FIXCA (wraps FFFF->0000). LEN -= 1 (wraps 0000->FFFF).
- NextREUA: REUA += 1 unless FIXREUA; wraps at 2^REUA_W.
- Length1 = (LEN == 16'h0001); combinational from the working LEN.
- XferEnd: EXEC <= 0, ff00_seen <= 0, EOB <= 1.
- VerifyErr: VERR <= 1.
- Autoload && AUTOLOAD: CA, REUA and LEN <= shadow values. Autoload overrides Next* on the same edge.
- IRQ flag (b7) = IE && ((EOB && EOBM) || (VERR && VERRM)). nIRQ = !IRQ, registered.
- Simultaneous events:
  - CPU write vs Next*/Autoload on the same register: CPU write wins.
  - Status read on the same edge as XferEnd or VerifyErr: set wins, flag stays 1.
  - CPU write of EXEC=1 on the same edge as XferEnd: the write wins, EXEC = 1.
- Reset values:
  - All registers and shadows 0, except CA=0, REUA=0, LEN=16'hFFFF with shadows equal.
  - EXEC=0, ff00_seen=0; Execute=0, nIRQ=1.
  - Dout reflects the reset state.
- Reset mid-transfer: all state clears on the next falling edge and Execute drops. dma_seq gates its own reset while DMA is active; no interlock is needed here.

Decomposition:
- Package reu_pkg:
  - Register offsets REG_STATUS..REG_ACR.
  - XFER_C64REU/REUC64/SWAP/VERIFY codes.
  - Status, command, IMR and ACR bit positions.
  - LEN_RESET constant.
- Sub-module reu_shadow_counter (parameter W): working plus shadow register, with byte-lane load, increment/decrement enable, fix-gate and autoload. Instantiated three times (CA, REUA, LEN).

Test Plan:
- Reset, then read A=0..A -> status 8'h10, CA 0000, REUA bank reads 8'hF8, LEN FFFF, Execute=0, nIRQ=1.
- Write CA=$C000, REUA=$012345, LEN=$0002, cmd=$90; pulse NextCA+NextREUA ×1 -> Execute=1 one edge after the cmd write, CA=$C001, REUA=$012346, LEN=$0001, Length1=1.
- cmd=$80 (FF00DIS=0) -> Execute stays 0; FF00Wr pulse -> Execute=1 next edge; XferEnd -> Execute=0, status b6=1.
- AUTOLOAD: cmd=$B0, step 5 bytes, then Autoload+XferEnd -> CA/REUA/LEN equal the written shadows, EXEC=0.
- IMR=$E0, VerifyErr pulse -> status $B0 (IRQ+VERR+SIZE), nIRQ=0 next edge; read status -> VERR clears, nIRQ=1 after one edge.
- ACR=$40, 3× NextREUA with REUA=$07FFFF -> REUA holds $07FFFF; ACR=$00 -> REUA wraps to $000000.
